// File: rtl/uart_frame_rx.sv
// uart_frame_rx: pulls bytes from the uart rx FIFO, hunts for SOF, buffers a
// LEN-byte payload, verifies the additive checksum and streams good payloads
// out on a valid/ready interface. Bad, oversize and stalled frames are
// dropped, flagged with a one-cycle error pulse and counted.
module uart_frame_rx #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_LEN    = 16,
  parameter logic [DATA_WIDTH-1:0] SOF        = 8'hA5,
  parameter int                    CNT_WIDTH  = 16,
  parameter int                    TIMEOUT    = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_empty,
  output logic                  rx_read,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  frame_last,
  output logic                  frame_ok,
  output logic                  err_chk,
  output logic                  err_len,
  output logic                  err_timeout,
  output logic [7:0]            err_count,
  output logic                  busy
);

  localparam int                    IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DATA_WIDTH-1:0] ZERO_B    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_B     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
  localparam bit                    TMO_EN    = (TIMEOUT > 32'sd0);
  // Compare against TIMEOUT-1 on the current count so the pulse lands on the
  // same edge at which the counter would have reached TIMEOUT.
  localparam logic [CNT_WIDTH-1:0]  TMO_LAST  = TMO_EN ? CNT_WIDTH'(TIMEOUT - 1) : {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_EMIT    = 3'd4
  } state_t;

  // 8-bit wrapping checksum accumulate
  function automatic logic [DATA_WIDTH-1:0] chk_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  // saturating error counter increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  state_t                  state_r, state_nxt_s;
  logic                    rd_wait_r;
  logic [DATA_WIDTH-1:0]   len_r, len_nxt_s;
  logic [DATA_WIDTH-1:0]   sum_r, sum_nxt_s;
  logic [IDX_W-1:0]        idx_r, idx_nxt_s, idx_inc_s;
  logic [CNT_WIDTH-1:0]    tmo_cnt_r, tmo_cnt_nxt_s;
  logic [DATA_WIDTH-1:0]   buf_r [MAX_LEN];
  logic                    buf_we_s;
  logic                    fetch_s, tmo_active_s, tmo_fire_s, idx_is_last_s;
  logic                    frame_valid_r, valid_nxt_s;
  logic [DATA_WIDTH-1:0]   frame_data_r, data_nxt_s;
  logic                    frame_last_r, last_nxt_s;
  logic                    frame_ok_r, ok_nxt_s;
  logic                    err_chk_r, err_chk_nxt_s;
  logic                    err_len_r, err_len_nxt_s;
  logic                    err_tmo_r, err_tmo_nxt_s;
  logic [7:0]              err_count_r;
  logic                    busy_r;

  // Fetch qualification and timeout expiry; a fetched byte beats expiry.
  always_comb begin
    fetch_s       = !rx_empty && !rd_wait_r && (state_r != S_EMIT);
    tmo_active_s  = (state_r == S_LEN) || (state_r == S_PAYLOAD) || (state_r == S_CHK);
    tmo_fire_s    = TMO_EN && tmo_active_s && !fetch_s && (tmo_cnt_r == TMO_LAST);
    idx_inc_s     = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    idx_is_last_s = (DATA_WIDTH'(idx_r) == (len_r - ONE_B));
  end

  // Frame FSM next state, datapath updates and next registered outputs.
  always_comb begin
    state_nxt_s   = state_r;
    len_nxt_s     = len_r;
    sum_nxt_s     = sum_r;
    idx_nxt_s     = idx_r;
    buf_we_s      = 1'b0;
    valid_nxt_s   = 1'b0;
    data_nxt_s    = ZERO_B;
    last_nxt_s    = 1'b0;
    ok_nxt_s      = 1'b0;
    err_chk_nxt_s = 1'b0;
    err_len_nxt_s = 1'b0;
    err_tmo_nxt_s = 1'b0;
    case (state_r)
      S_HUNT: begin
        if (fetch_s && (rx_data == SOF)) begin
          state_nxt_s = S_LEN;
        end else begin
          state_nxt_s = S_HUNT;
        end
      end
      S_LEN: begin
        if (fetch_s) begin
          if ((rx_data != ZERO_B) && (rx_data <= MAX_LEN_B)) begin
            len_nxt_s   = rx_data;
            sum_nxt_s   = rx_data;
            idx_nxt_s   = {IDX_W{1'b0}};
            state_nxt_s = S_PAYLOAD;
          end else begin
            err_len_nxt_s = 1'b1;
            state_nxt_s   = S_HUNT;
          end
        end else if (tmo_fire_s) begin
          err_tmo_nxt_s = 1'b1;
          state_nxt_s   = S_HUNT;
        end else begin
          state_nxt_s = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (fetch_s) begin
          buf_we_s  = 1'b1;
          sum_nxt_s = chk_add(sum_r, rx_data);
          if (idx_is_last_s) begin
            state_nxt_s = S_CHK;
          end else begin
            idx_nxt_s = idx_inc_s;
          end
        end else if (tmo_fire_s) begin
          err_tmo_nxt_s = 1'b1;
          state_nxt_s   = S_HUNT;
        end else begin
          state_nxt_s = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (fetch_s) begin
          if (chk_add(sum_r, rx_data) == ZERO_B) begin
            state_nxt_s = S_EMIT;
            idx_nxt_s   = {IDX_W{1'b0}};
            valid_nxt_s = 1'b1;
            data_nxt_s  = buf_r[{IDX_W{1'b0}}];
            last_nxt_s  = (len_r == ONE_B);
          end else begin
            err_chk_nxt_s = 1'b1;
            state_nxt_s   = S_HUNT;
          end
        end else if (tmo_fire_s) begin
          err_tmo_nxt_s = 1'b1;
          state_nxt_s   = S_HUNT;
        end else begin
          state_nxt_s = S_CHK;
        end
      end
      S_EMIT: begin
        if (frame_ready) begin
          if (frame_last_r) begin
            ok_nxt_s    = 1'b1;
            state_nxt_s = S_HUNT;
          end else begin
            idx_nxt_s   = idx_inc_s;
            valid_nxt_s = 1'b1;
            data_nxt_s  = buf_r[idx_inc_s];
            last_nxt_s  = (DATA_WIDTH'(idx_inc_s) == (len_r - ONE_B));
          end
        end else begin
          valid_nxt_s = 1'b1;
          data_nxt_s  = frame_data_r;
          last_nxt_s  = frame_last_r;
        end
      end
      default: begin
        state_nxt_s = S_HUNT;
      end
    endcase
  end

  // Inter-byte timer: cleared by a fetch, by any state change or when idle.
  always_comb begin
    if (!tmo_active_s || fetch_s || (state_nxt_s != state_r)) begin
      tmo_cnt_nxt_s = {CNT_WIDTH{1'b0}};
    end else if (tmo_cnt_r != CNT_MAX) begin
      tmo_cnt_nxt_s = tmo_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_nxt_s = tmo_cnt_r;
    end
  end

  // Control state; rd_wait comes out of reset set so nothing pops during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_HUNT;
      rd_wait_r <= 1'b1;
      len_r     <= ZERO_B;
      sum_r     <= ZERO_B;
      idx_r     <= {IDX_W{1'b0}};
      tmo_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      rd_wait_r <= fetch_s;
      len_r     <= len_nxt_s;
      sum_r     <= sum_nxt_s;
      idx_r     <= idx_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_r[idx_r] <= rx_data;
    end
  end

  // Registered stream, status pulses and saturating error count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_valid_r <= 1'b0;
      frame_data_r  <= ZERO_B;
      frame_last_r  <= 1'b0;
      frame_ok_r    <= 1'b0;
      err_chk_r     <= 1'b0;
      err_len_r     <= 1'b0;
      err_tmo_r     <= 1'b0;
      err_count_r   <= 8'h00;
      busy_r        <= 1'b0;
    end else begin
      frame_valid_r <= valid_nxt_s;
      frame_data_r  <= data_nxt_s;
      frame_last_r  <= last_nxt_s;
      frame_ok_r    <= ok_nxt_s;
      err_chk_r     <= err_chk_nxt_s;
      err_len_r     <= err_len_nxt_s;
      err_tmo_r     <= err_tmo_nxt_s;
      busy_r        <= (state_nxt_s != S_HUNT);
      if (err_chk_nxt_s || err_len_nxt_s || err_tmo_nxt_s) begin
        err_count_r <= sat_inc8(err_count_r);
      end
    end
  end

  assign rx_read     = fetch_s;
  assign frame_data  = frame_data_r;
  assign frame_valid = frame_valid_r;
  assign frame_last  = frame_last_r;
  assign frame_ok    = frame_ok_r;
  assign err_chk     = err_chk_r;
  assign err_len     = err_len_r;
  assign err_timeout = err_tmo_r;
  assign err_count   = err_count_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: a FIFO model feeds bytes, a generator builds whole
// frames and pushes the expected payload bytes and status events into
// queues, and a monitor pops and compares whenever the DUT presents output.
module tb_uart_frame_rx;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 100;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         EV_OK = 0, EV_CHK = 1, EV_LEN = 2, EV_TMO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rx_read;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_ready = 1'b0;
  logic       frame_last;
  logic       frame_ok, err_chk, err_len, err_timeout;
  logic [7:0] err_count;
  logic       busy;

  uart_frame_rx #(
    .DATA_WIDTH(8), .MAX_LEN(MAX_LEN), .SOF(SOF), .CNT_WIDTH(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty), .rx_read(rx_read),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_last(frame_last), .frame_ok(frame_ok), .err_chk(err_chk), .err_len(err_len),
    .err_timeout(err_timeout), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] src_q[$];       // bytes not yet arrived in the FIFO
  logic [7:0] fifo_q[$];      // uart rx FIFO contents
  logic [8:0] exp_data_q[$];  // {last, data}
  int         exp_evt_q[$];
  int         model_err = 0;
  int         last_pop_cyc = 0;
  bit         pop_pend = 1'b0;
  bit         hold_ready_low = 1'b0;
  int         gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_read"}, rx_read, 0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_frame_data"}, frame_data, 0);
    check({tag, "_frame_last"}, frame_last, 0);
    check({tag, "_frame_ok"}, frame_ok, 0);
    check({tag, "_err_chk"}, err_chk, 0);
    check({tag, "_err_len"}, err_len, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic handle_evt(input int code);
    int e;
    if (exp_evt_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got code=%0d while none expected", code);
    end else begin
      e = exp_evt_q.pop_front();
      check("event_code", code, e);
    end
    if (code != EV_OK) begin
      if (model_err < 255) model_err++;
      check("err_count", err_count, model_err);
    end
    // The pulse rises TIMEOUT edges after the edge that popped the last byte,
    // so it is first seen TIMEOUT+1 sample points after rx_read was seen.
    if (code == EV_TMO) check("timeout_latency", cyc - last_pop_cyc, TIMEOUT + 1);
  endtask

  // FIFO model and consumer: update inputs just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pend = 1'b0;
      if (src_q.size() > 0) begin
        if (gap >= 6 || $urandom_range(0, 2) != 0) begin
          fifo_q.push_back(src_q.pop_front());
          gap = 0;
        end else begin
          gap++;
        end
      end else begin
        gap = 0;
      end
      rx_empty = (fifo_q.size() == 0);
      if (rx_empty) rx_data = 8'h00;
      else rx_data = fifo_q[0];
      frame_ready = hold_ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: sample on the falling edge, pop and compare.
  initial begin : monitor
    logic [8:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (frame_valid) begin
          if (exp_data_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: frame_data=%0h while no payload byte expected", frame_data);
          end else if (frame_ready) begin
            w = exp_data_q.pop_front();
            check("frame_data", frame_data, w[7:0]);
            check("frame_last", frame_last, w[8]);
          end else begin
            check("stall_data_last", {frame_last, frame_data}, exp_data_q[0]);
            check("stall_no_fetch", rx_read, 0);
          end
        end
        if (frame_ok)    handle_evt(EV_OK);
        if (err_chk)     handle_evt(EV_CHK);
        if (err_len)     handle_evt(EV_LEN);
        if (err_timeout) handle_evt(EV_TMO);
        pop_pend = rx_read;
        if (rx_read) last_pop_cyc = cyc;
      end
    end
  end

  task automatic put(input logic [7:0] b);
    src_q.push_back(b);
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic l);
    exp_data_q.push_back({l, d});
  endtask

  task automatic junk();
    int n;
    logic [7:0] b;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SOF) b = 8'h00;
      put(b);
    end
  endtask

  // Whole frame; bad=1 corrupts the checksum byte.
  task automatic frame(input int len, input bit bad);
    int sum, chk;
    logic [7:0] b;
    sum = len;
    put(SOF);
    put(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      sum += int'(b);
      put(b);
      if (!bad) exp_byte(b, i == len - 1);
    end
    chk = (256 - (sum % 256)) % 256;
    if (bad) chk = (chk + $urandom_range(1, 255)) % 256;
    put(8'(chk));
    exp_evt_q.push_back(bad ? EV_CHK : EV_OK);
  endtask

  task automatic bad_len_frame();
    put(SOF);
    if ($urandom_range(0, 1) == 0) put(8'h00);
    else put(8'($urandom_range(MAX_LEN + 1, 255)));
    exp_evt_q.push_back(EV_LEN);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (n < budget && !(src_q.size() == 0 && fifo_q.size() == 0 && exp_data_q.size() == 0 &&
                           exp_evt_q.size() == 0 && !busy)) begin
      @(negedge clk);
      n++;
    end
    check(name, n < budget, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // good 3-byte frame
    put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h97);
    exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b1);
    exp_evt_q.push_back(EV_OK);
    wait_idle(500, "t1_drain");
    check("t1_err_count", err_count, 0);

    // bad checksum
    put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h98);
    exp_evt_q.push_back(EV_CHK);
    wait_idle(500, "t2_drain");
    check("t2_err_count", err_count, 1);

    // leading junk, single-byte payload
    put(8'h00); put(8'hFF); put(8'hA5); put(8'h01); put(8'h7E); put(8'h81);
    exp_byte(8'h7E, 1'b1);
    exp_evt_q.push_back(EV_OK);
    wait_idle(500, "t3_drain");

    // LEN 0 and LEN 17, then a good frame
    put(8'hA5); put(8'h00); put(8'hA5); put(8'h11);
    put(8'hA5); put(8'h01); put(8'h7E); put(8'h81);
    exp_evt_q.push_back(EV_LEN); exp_evt_q.push_back(EV_LEN);
    exp_byte(8'h7E, 1'b1);
    exp_evt_q.push_back(EV_OK);
    wait_idle(500, "t4_drain");
    check("t4_err_count", err_count, 3);

    // randomized mix including MAX_LEN and SOF-valued payload bytes
    for (int i = 0; i < 60; i++) begin
      junk();
      n = $urandom_range(0, 9);
      if (n < 6) frame((i % 7 == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN), 1'b0);
      else if (n < 8) frame($urandom_range(1, MAX_LEN), 1'b1);
      else bad_len_frame();
    end
    wait_idle(20000, "rand_drain");

    // timeouts in PAYLOAD, LEN and CHK, each followed by a good frame
    put(8'hA5); put(8'h02); put(8'h10);
    exp_evt_q.push_back(EV_TMO);
    wait_idle(1000, "tmo_payload_drain");
    put(8'hA5);
    exp_evt_q.push_back(EV_TMO);
    wait_idle(1000, "tmo_len_drain");
    put(8'hA5); put(8'h01); put(8'h33);
    exp_evt_q.push_back(EV_TMO);
    wait_idle(1000, "tmo_chk_drain");
    frame(5, 1'b0);
    wait_idle(1000, "post_tmo_drain");

    // backpressure: stall 20 cycles mid-EMIT with bytes waiting in the FIFO
    hold_ready_low = 1'b1;
    frame(4, 1'b0);
    put(8'h01); put(8'h02); put(8'h03);
    n = 0;
    while (n < 500 && !frame_valid) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", n < 500, 1);
    repeat (20) @(negedge clk);
    hold_ready_low = 1'b0;
    wait_idle(1000, "stall_drain");

    // async reset mid-PAYLOAD
    put(8'hA5); put(8'h08); put(8'h01); put(8'h02); put(8'h03);
    n = 0;
    while (n < 500 && (src_q.size() != 0 || fifo_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    check("mid_frame_fed", n < 500, 1);
    repeat (4) @(negedge clk);
    check("mid_frame_busy", busy, 1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    src_q.delete();
    fifo_q.delete();
    exp_data_q.delete();
    exp_evt_q.delete();
    model_err = 0;
    pop_pend = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    put(8'hA5); put(8'h01); put(8'h7E); put(8'h81);
    exp_byte(8'h7E, 1'b1);
    exp_evt_q.push_back(EV_OK);
    wait_idle(500, "post_rst_drain");

    // error counter saturation
    for (int i = 0; i < 300; i++) bad_len_frame();
    wait_idle(20000, "sat_drain");
    check("sat_err_count", err_count, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
